// File: rtl/mem_bank_pkg.sv
// Shared sizing constants and address-decode helpers for the banked memory array.
package mem_bank_pkg;
    localparam int NUM_BANKS        = 4;
    localparam int BANK_ROWS        = 8192;
    localparam int WORD_W           = 16;
    localparam int ADDR_W           = 16;
    localparam int BANK_BUSY_CYCLES = 4;
    localparam int READ_LATENCY     = 2;

    localparam int BANK_W = $clog2(NUM_BANKS);
    localparam int ROW_W  = $clog2(BANK_ROWS);
    localparam int CNT_W  = $clog2(BANK_BUSY_CYCLES);

    // addr[0] is the byte lane, the next BANK_W bits pick the bank, the rest the row.
    function automatic logic [BANK_W-1:0] bank_of(input logic [ADDR_W-1:0] a);
        return a[BANK_W:1];
    endfunction

    function automatic logic [ROW_W-1:0] row_of(input logic [ADDR_W-1:0] a);
        return a[ADDR_W-1:BANK_W+1];
    endfunction
endpackage

// File: rtl/mem_bank.sv
// One storage bank: word array, registered read port and an occupancy down-counter.
module mem_bank
    import mem_bank_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              we,
    input  logic [ROW_W-1:0]  row,
    input  logic [WORD_W-1:0] wdata,
    output logic [WORD_W-1:0] rdata,
    output logic              busy
);
    logic [WORD_W-1:0] mem [BANK_ROWS];
    logic [CNT_W-1:0]  cnt;

    // Loading BUSY_CYCLES-1 keeps the bank occupied for the three cycles after acceptance.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= CNT_W'(BANK_BUSY_CYCLES - 1);
        end else if (cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign busy = (cnt != '0);

    // Storage is deliberately not reset so contents survive a reset pulse.
    always_ff @(posedge clk) begin
        if (en && we) begin
            mem[row] <= wdata;
        end
        if (en && !we) begin
            rdata <= mem[row];
        end
    end
endmodule

// File: rtl/mem_bank_array.sv
// Four-bank memory with per-bank occupancy, stall/err arbitration and a 2-cycle read return.
// Optional alignment checking is enabled by defining MEM_ALIGN_CHECK_EN.
module mem_bank_array
    import mem_bank_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic [ADDR_W-1:0]    addr,
    input  logic [WORD_W-1:0]    data_in,
    input  logic                 wr,
    input  logic                 rd,
    output logic [WORD_W-1:0]    data_out,
    output logic [NUM_BANKS-1:0] busy,
    output logic                 stall,
    output logic                 err
);
    logic                 valid_req;
    logic                 align_err;
    logic                 err_c;
    logic                 accept;
    logic [BANK_W-1:0]    bank_p0;
    logic [ROW_W-1:0]     row_p0;
    logic [NUM_BANKS-1:0] busy_vec;
    logic [WORD_W-1:0]    bank_rdata [NUM_BANKS];

    logic                 vld_p1;
    logic [BANK_W-1:0]    bank_p1;
    logic                 vld_p2;
    logic [WORD_W-1:0]    data_p2;

    // Stage p0: decode and arbitration, all combinational.
    assign valid_req = rd ^ wr;
    assign bank_p0   = bank_of(addr);
    assign row_p0    = row_of(addr);

`ifdef MEM_ALIGN_CHECK_EN
    assign align_err = valid_req & addr[0];
`else
    logic unused_lsb;
    assign unused_lsb = addr[0];
    assign align_err  = 1'b0;
`endif

    assign err_c  = !rst && ((rd && wr) || align_err);
    assign stall  = !rst && valid_req && !err_c && busy_vec[bank_p0];
    assign accept = !rst && valid_req && !err_c && !busy_vec[bank_p0];
    assign err    = err_c;
    assign busy   = busy_vec;

    for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
        mem_bank u_bank (
            .clk   (clk),
            .rst   (rst),
            .en    (accept && (bank_p0 == BANK_W'(b))),
            .we    (wr),
            .row   (row_p0),
            .wdata (data_in),
            .rdata (bank_rdata[b]),
            .busy  (busy_vec[b])
        );
    end

    // Stage p1/p2 control: valids are the only reset pipeline state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_p1 <= 1'b0;
            vld_p2 <= 1'b0;
        end else begin
            vld_p1 <= accept && rd;
            vld_p2 <= vld_p1;
        end
    end

    // Stage p1 -> p2 data: pick the bank's registered read word.
    always_ff @(posedge clk) begin
        bank_p1 <= bank_p0;
        data_p2 <= bank_rdata[bank_p1];
    end

    assign data_out = vld_p2 ? data_p2 : '0;
endmodule

// File: tb/tb_mem_bank_array.sv
// Directed plus randomized bench for mem_bank_array against a cycle-indexed reference model.
module tb_mem_bank_array;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] addr = '0;
    logic [15:0] data_in = '0;
    logic        wr = 1'b0;
    logic        rd = 1'b0;
    logic [15:0] data_out;
    logic [3:0]  busy;
    logic        stall;
    logic        err;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

`ifdef MEM_ALIGN_CHECK_EN
    localparam bit ALIGN_CHK = 1'b1;
`else
    localparam bit ALIGN_CHK = 1'b0;
`endif

    // Reference model: memory keyed by word address, next free cycle per bank,
    // and expected read returns keyed by the cycle they must appear in.
    logic [15:0] mem_m [int];
    int          bank_free [4];
    logic [15:0] ret_data [int];
    bit          ret_unk [int];
    logic [15:0] written [$];

    mem_bank_array dut (
        .clk      (clk),
        .rst      (rst),
        .addr     (addr),
        .data_in  (data_in),
        .wr       (wr),
        .rd       (rd),
        .data_out (data_out),
        .busy     (busy),
        .stall    (stall),
        .err      (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic step(input logic r, input logic w, input logic [15:0] a, input logic [15:0] d);
        logic       valid, e, s, known;
        logic [1:0] b;
        logic [3:0] busy_e;
        logic [15:0] dout_e;
        @(negedge clk);
        rst = 1'b0; rd = r; wr = w; addr = a; data_in = d;
        #1;
        valid = r ^ w;
        e     = (r && w) || (valid && a[0] && ALIGN_CHK);
        b     = a[2:1];
        for (int i = 0; i < 4; i++) busy_e[i] = (cyc < bank_free[i]);
        s      = valid && !e && busy_e[b];
        dout_e = ret_data.exists(cyc) ? ret_data[cyc] : 16'h0000;
        known  = !ret_unk.exists(cyc);
        check("err", {15'h0, err}, {15'h0, e});
        check("stall", {15'h0, stall}, {15'h0, s});
        check("busy", {12'h0, busy}, {12'h0, busy_e});
        if (known) check("data_out", data_out, dout_e);
        ret_data.delete(cyc);
        ret_unk.delete(cyc);
        if (valid && !e && !s) begin
            bank_free[b] = cyc + 4;
            if (w) begin
                mem_m[int'(a[15:1])] = d;
                written.push_back(a);
            end else if (mem_m.exists(int'(a[15:1]))) begin
                ret_data[cyc + 2] = mem_m[int'(a[15:1])];
            end else begin
                ret_unk[cyc + 2] = 1'b1;
            end
        end
        cyc++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 16'h0000, 16'h0000);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; rd = 1'b1; wr = 1'b1; addr = 16'h0100;
        #1;
        check("rst_busy", {12'h0, busy}, 16'h0000);
        check("rst_data_out", data_out, 16'h0000);
        check("rst_stall", {15'h0, stall}, 16'h0000);
        check("rst_err", {15'h0, err}, 16'h0000);
        ret_data.delete();
        ret_unk.delete();
        for (int i = 0; i < 4; i++) bank_free[i] = 0;
        cyc++;
    endtask

    initial begin
        logic [15:0] a;
        logic [15:0] d;
        int          op;
        for (int i = 0; i < 4; i++) bank_free[i] = 0;

        do_reset();

        // Burst of writes to all four banks, then reads back with no bubble.
        step(1'b0, 1'b1, 16'h1230, 16'hA0A0);
        step(1'b0, 1'b1, 16'h1232, 16'hA1A1);
        step(1'b0, 1'b1, 16'h1234, 16'hA2A2);
        step(1'b0, 1'b1, 16'h1236, 16'hA3A3);
        step(1'b1, 1'b0, 16'h1230, 16'h0000);
        step(1'b1, 1'b0, 16'h1232, 16'h0000);
        step(1'b1, 1'b0, 16'h1234, 16'h0000);
        step(1'b1, 1'b0, 16'h1236, 16'h0000);
        idle(3);

        // Same-bank conflict: second read stalls three cycles, then is accepted.
        step(1'b0, 1'b1, 16'h0040, 16'h4040);
        step(1'b0, 1'b1, 16'h004A, 16'h0000);
        idle(3);
        step(1'b0, 1'b1, 16'h0048, 16'h4848);
        idle(4);
        step(1'b1, 1'b0, 16'h0040, 16'h0000);
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 16'h0048, 16'h0000);
        idle(3);

        // Illegal rd&wr: err, no access, no return.
        step(1'b1, 1'b1, 16'h0100, 16'hDEAD);
        idle(3);

        // Odd address: err with alignment checking, word 0x0100 otherwise.
        step(1'b0, 1'b1, 16'h0100, 16'h5A5A);
        idle(4);
        step(1'b1, 1'b0, 16'h0101, 16'h0000);
        idle(3);

        // Reset while a read is in flight; storage must survive.
        step(1'b0, 1'b1, 16'h0200, 16'hC3C3);
        idle(4);
        step(1'b1, 1'b0, 16'h0200, 16'h0000);
        do_reset();
        step(1'b1, 1'b0, 16'h0200, 16'h0000);
        idle(3);

        // Randomized traffic over a small address window to provoke conflicts.
        for (int n = 0; n < 400; n++) begin
            op = $urandom_range(0, 9);
            a  = 16'($urandom_range(0, 63));
            d  = 16'($urandom);
            if (op == 0) begin
                step(1'b1, 1'b1, a, d);
            end else if (op <= 4 || written.size() == 0) begin
                step(1'b0, 1'b1, a, d);
            end else if (op <= 8) begin
                a = written[$urandom_range(0, written.size() - 1)];
                a[0] = 1'($urandom_range(0, 1));
                step(1'b1, 1'b0, a, 16'h0000);
            end else begin
                idle(1);
            end
            if (n == 200) do_reset();
        end
        idle(4);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/mem_bank_array.md
MEM_BANK_ARRAY -- requirements
Module: mem_bank_array

Interface
REQ-001 SHALL have port: clk  input  1  sole clock; all state updates on rising edge.
REQ-002 SHALL have port: rst  input  1  reset; asynchronous, active-high.
REQ-003 SHALL have port: addr  input  16  byte address; addr[2:1] selects bank, addr[15:3] selects word row within bank.
REQ-004 SHALL have port: data_in  input  16  write data.
REQ-005 SHALL have port: wr  input  1  write request.
REQ-006 SHALL have port: rd  input  1  read request.
REQ-007 SHALL have port: data_out  output  16  read data; valid only in the read-return cycle, 16'h0000 otherwise.
REQ-008 SHALL have port: busy  output  4  per-bank occupancy; busy[b]=1 means bank b cannot accept a request this cycle.
REQ-009 SHALL have port: stall  output  1  current request is rejected because its bank is busy.
REQ-010 SHALL have port: err  output  1  current request is illegal and is not performed.

Function
REQ-011 Banks: 4 independent banks of 8192 x 16-bit words; bank b at row r holds byte address {r, b, 1'b0}.
REQ-012 Request valid in cycle T iff exactly one of rd/wr is high; rd & wr both high SHALL assert err combinationally, perform no access and change no busy counter.
REQ-013 Request accepted in cycle T iff valid, err=0 and busy[addr[2:1]]=0; stall SHALL be 0 for accepted requests.
REQ-014 stall SHALL be combinational: valid request & busy[addr[2:1]]; stalled request performs no access; requester must hold or reissue.
REQ-015 Bank occupancy: on acceptance at T, busy[bank] SHALL be 1 in cycles T+1, T+2, T+3 and 0 from T+4 (2-bit down-counter loaded with 3); same bank accepts again at T+4 at earliest.
REQ-016 Requests to different banks SHALL be accepted in consecutive cycles with no bubble (4 accesses in 4 cycles to banks 0..3).
REQ-017 Write: accepted write at T SHALL update storage at the T clock edge with data_in; produces no data_out.
REQ-018 Read: accepted read at T SHALL drive the addressed word on data_out during cycle T+2 only, via a 2-stage valid+data pipeline shared by all banks.
REQ-019 Back-to-back reads to different banks at T and T+1 SHALL return data at T+2 and T+3 respectively, in order.
REQ-020 Read of a location written by an accepted write at T, issued at T+4 or later, SHALL return the new data.
REQ-021 Stalled or erroring requests SHALL NOT enter the read pipeline.
REQ-022 Unwritten locations return undefined data; verification SHALL not rely on them.

Reset
REQ-023 rst high SHALL immediately clear all bank counters (busy=4'b0000), read-pipeline valids, and data_out to 16'h0000.
REQ-024 stall and err SHALL be 0 while rst is high, regardless of rd/wr.
REQ-025 Reset mid-operation: in-flight reads SHALL be discarded (no data_out after release); storage contents SHALL NOT be reset.
REQ-026 First request SHALL be accepted in the first cycle after rst deasserts.

Configuration
REQ-027 Macro MEM_ALIGN_CHECK_EN: when defined, a valid request with addr[0]=1 SHALL assert err and be dropped like REQ-012; when undefined, addr[0] is ignored and no alignment err is generated.

Structure
REQ-028 Shared package mem_bank_pkg SHALL hold NUM_BANKS=4, BANK_ROWS=8192, WORD_W=16, ADDR_W=16, BANK_BUSY_CYCLES=4, READ_LATENCY=2.
REQ-029 Sub-module mem_bank (storage array, busy down-counter, registered read port) SHALL be instantiated 4 times; top holds decode, stall/err logic, and the read-return pipeline.

Verification
REQ-030 Reset: rst pulse mid-run -> busy=0000, data_out=0000, stall=0, err=0 in the same cycle.
REQ-031 Burst write then read: wr 0x1230/0x1232/0x1234/0x1236 with data A0A0/A1A1/A2A2/A3A3 at T..T+3, rd same addresses T+4..T+7 -> data_out A0A0..A3A3 at T+6..T+9, stall never 1.
REQ-032 Bank conflict: rd 0x0040 at T, rd 0x0048 (same bank 0) at T+1..T+3 -> stall=1, busy[0]=1; accepted at T+4, data at T+6.
REQ-033 Illegal: rd=wr=1 at 0x0100 -> err=1, busy unchanged, no data_out two cycles later.
REQ-034 Alignment: rd 0x0101 -> err=1 with MEM_ALIGN_CHECK_EN defined; without it, returns word at 0x0100 at T+2, err=0.
REQ-035 Reset during read: rd 0x0200 at T, rst at T+1 -> data_out stays 0000 at T+2.
